// File: rtl/vc_flits_buffer_pkg.sv
// Shared NIC definitions for the multi-VC receive buffer: flit type codes,
// flit type field width, default sizes and the per-VC state encoding.
package vc_flits_buffer_pkg;

    localparam int DEF_FLIT_WIDTH    = 32;
    localparam int DEF_N_VC          = 4;
    localparam int MAX_PACKET_LENGHT = 4;
    localparam int FLIT_TYPE_BITS    = 2;

    typedef enum logic [1:0] {
        FLIT_HEAD      = 2'b00,
        FLIT_BODY      = 2'b01,
        FLIT_TAIL      = 2'b10,
        FLIT_HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        VC_IDLE      = 2'b00,
        VC_RECEIVING = 2'b01,
        VC_REQUEST   = 2'b10
    } vc_state_e;

endpackage

// File: rtl/vc_flits_buffer_if.sv
// Router-side flit link and packet-to-message handshake of the multi-VC buffer.
// slave is the buffer side, master is the router / next-stage side.
interface vc_flits_buffer_if #(
    parameter int FLIT_WIDTH  = 32,
    parameter int N_VC        = 4,
    parameter int MAX_PKT_LEN = 4,
    parameter int N_BITS_VC   = $clog2(N_VC),
    parameter int N_BITS_LEN  = $clog2(MAX_PKT_LEN + 1)
);
    logic [FLIT_WIDTH-1:0]             in_link_i;
    logic                              is_valid_i;
    logic [N_BITS_VC-1:0]              in_vc_i;
    logic [N_VC-1:0]                   credit_signal_o;
    logic [N_VC-1:0]                   free_signal_o;
    logic                              r_pkt_to_msg_o;
    logic                              g_pkt_to_msg_i;
    logic [MAX_PKT_LEN*FLIT_WIDTH-1:0] out_link_o;
    logic [N_BITS_VC-1:0]              out_vc_o;
    logic [N_BITS_LEN-1:0]             out_len_o;
    logic                              err_o;

    modport slave (
        input  in_link_i, is_valid_i, in_vc_i, g_pkt_to_msg_i,
        output credit_signal_o, free_signal_o, r_pkt_to_msg_o,
        output out_link_o, out_vc_o, out_len_o, err_o
    );

    modport master (
        output in_link_i, is_valid_i, in_vc_i, g_pkt_to_msg_i,
        input  credit_signal_o, free_signal_o, r_pkt_to_msg_o,
        input  out_link_o, out_vc_o, out_len_o, err_o
    );
endinterface

// File: rtl/vc_flits_buffer_assembler.sv
// One virtual channel: reassembles a single packet into its slot storage.
// clear is only ever raised by the arbiter while this VC sits in REQUEST.
module vc_packet_assembler
    import vc_flits_buffer_pkg::*;
#(
    parameter int FLIT_WIDTH  = DEF_FLIT_WIDTH,
    parameter int MAX_PKT_LEN = MAX_PACKET_LENGHT,
    parameter int N_BITS_LEN  = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              store_en,
    input  logic [FLIT_WIDTH-1:0]             flit,
    input  logic                              clear,
    output vc_state_e                         state,
    output logic [N_BITS_LEN-1:0]             cnt,
    output logic [MAX_PKT_LEN*FLIT_WIDTH-1:0] pkt,
    output logic                              err
);
    localparam int SLOT_W = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
    localparam logic [N_BITS_LEN-1:0] LAST_BODY = N_BITS_LEN'(MAX_PKT_LEN - 1);
    localparam logic [N_BITS_LEN-1:0] ONE_FLIT  = N_BITS_LEN'(1);

    vc_state_e                              state_r;
    vc_state_e                              state_n_s;
    logic [N_BITS_LEN-1:0]                  cnt_r;
    logic [N_BITS_LEN-1:0]                  cnt_n_s;
    logic [MAX_PKT_LEN-1:0][FLIT_WIDTH-1:0] slots_r;
    logic                                   wr_en_s;
    logic [SLOT_W-1:0]                      wr_slot_s;
    logic                                   err_s;
    flit_type_e                             type_s;

    assign type_s = flit_type_e'(flit[FLIT_WIDTH-1 -: FLIT_TYPE_BITS]);

    // Next state, write slot and protocol-error decode for a flit on this VC
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        wr_en_s   = 1'b0;
        wr_slot_s = '0;
        err_s     = 1'b0;
        if (clear) begin
            // Granted this cycle: a concurrent flit finds the VC still in REQUEST
            state_n_s = VC_IDLE;
            cnt_n_s   = '0;
            err_s     = store_en;
        end else if (store_en) begin
            case (state_r)
                VC_IDLE: begin
                    case (type_s)
                        FLIT_HEAD: begin
                            wr_en_s   = 1'b1;
                            cnt_n_s   = ONE_FLIT;
                            state_n_s = VC_RECEIVING;
                        end
                        FLIT_HEAD_TAIL: begin
                            wr_en_s   = 1'b1;
                            cnt_n_s   = ONE_FLIT;
                            state_n_s = VC_REQUEST;
                        end
                        default: err_s = 1'b1;
                    endcase
                end
                VC_RECEIVING: begin
                    case (type_s)
                        FLIT_BODY: begin
                            if (cnt_r < LAST_BODY) begin
                                wr_en_s   = 1'b1;
                                wr_slot_s = SLOT_W'(cnt_r);
                                cnt_n_s   = cnt_r + ONE_FLIT;
                            end else begin
                                // No room left for the tail: abandon the packet
                                err_s     = 1'b1;
                                cnt_n_s   = '0;
                                state_n_s = VC_IDLE;
                            end
                        end
                        FLIT_TAIL: begin
                            wr_en_s   = 1'b1;
                            wr_slot_s = SLOT_W'(cnt_r);
                            cnt_n_s   = cnt_r + ONE_FLIT;
                            state_n_s = VC_REQUEST;
                        end
                        FLIT_HEAD: begin
                            err_s   = 1'b1;
                            wr_en_s = 1'b1;
                            cnt_n_s = ONE_FLIT;
                        end
                        default: begin
                            err_s     = 1'b1;
                            wr_en_s   = 1'b1;
                            cnt_n_s   = ONE_FLIT;
                            state_n_s = VC_REQUEST;
                        end
                    endcase
                end
                default: err_s = 1'b1;
            endcase
        end else begin
            err_s = 1'b0;
        end
    end

    // FSM state and flit count
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= VC_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    // Flit slot storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            slots_r[wr_slot_s] <= flit;
        end
    end

    assign state = state_r;
    assign cnt   = cnt_r;
    assign pkt   = slots_r;
    assign err   = err_s;

endmodule

// File: rtl/vc_flits_buffer.sv
// Multi-VC NoC-to-NIC receive buffer: per-VC packet assembly, round-robin
// locked offer of completed packets to the packet-to-message stage.
module vc_flits_buffer
    import vc_flits_buffer_pkg::*;
#(
    parameter int FLIT_WIDTH  = DEF_FLIT_WIDTH,
    parameter int N_VC        = DEF_N_VC,
    parameter int MAX_PKT_LEN = MAX_PACKET_LENGHT,
    parameter int N_BITS_VC   = $clog2(N_VC),
    parameter int N_BITS_LEN  = $clog2(MAX_PKT_LEN + 1)
) (
    input logic               clk,
    input logic               rst,
    vc_flits_buffer_if.slave  bus
);
    localparam logic [N_VC-1:0] VC_ONE = N_VC'(1);

    logic [N_VC-1:0]                   vc_store_s;
    logic [N_VC-1:0]                   vc_clear_s;
    logic [N_VC-1:0]                   vc_req_s;
    logic [N_VC-1:0]                   vc_err_s;
    vc_state_e                         vc_state_s [N_VC];
    logic [N_BITS_LEN-1:0]             vc_cnt_s   [N_VC];
    logic [MAX_PKT_LEN*FLIT_WIDTH-1:0] vc_pkt_s   [N_VC];

    logic                 lock_v_r;
    logic [N_BITS_VC-1:0] lock_vc_r;
    logic [N_BITS_VC-1:0] rr_ptr_r;
    logic [N_BITS_VC-1:0] rr_next_s;
    logic [N_BITS_VC-1:0] search_start_s;
    logic [N_VC-1:0]      search_mask_s;
    logic                 pick_v_s;
    logic [N_BITS_VC-1:0] pick_vc_s;
    logic                 grant_s;
    logic [N_VC-1:0]      credit_s;
    logic [N_VC-1:0]      free_s;

    // First requesting VC at or after start, wrapping at N_VC; MSB = found
    function automatic logic [N_BITS_VC:0] find_req(input logic [N_BITS_VC-1:0] start,
                                                    input logic [N_VC-1:0]      mask);
        logic                 found;
        logic [N_BITS_VC-1:0] idx;
        logic [N_BITS_VC-1:0] pos;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_VC; k++) begin
            pos = N_BITS_VC'((int'(start) + k) % N_VC);
            if (!found && mask[pos]) begin
                found = 1'b1;
                idx   = pos;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    for (genvar v = 0; v < N_VC; v++) begin : g_vc
        assign vc_store_s[v] = bus.is_valid_i & (bus.in_vc_i == N_BITS_VC'(v));
        assign vc_clear_s[v] = grant_s & (lock_vc_r == N_BITS_VC'(v));
        assign vc_req_s[v]   = (vc_state_s[v] == VC_REQUEST);

        vc_packet_assembler #(
            .FLIT_WIDTH  (FLIT_WIDTH),
            .MAX_PKT_LEN (MAX_PKT_LEN),
            .N_BITS_LEN  (N_BITS_LEN)
        ) u_asm (
            .clk      (clk),
            .rst      (rst),
            .store_en (vc_store_s[v]),
            .flit     (bus.in_link_i),
            .clear    (vc_clear_s[v]),
            .state    (vc_state_s[v]),
            .cnt      (vc_cnt_s[v]),
            .pkt      (vc_pkt_s[v]),
            .err      (vc_err_s[v])
        );
    end

    assign grant_s   = lock_v_r & bus.g_pkt_to_msg_i & ~rst;
    assign rr_next_s = N_BITS_VC'((int'(lock_vc_r) + 1) % N_VC);

    // Candidate for the next lock; the VC being granted is no longer eligible
    always_comb begin
        if (grant_s) begin
            search_start_s = rr_next_s;
            search_mask_s  = vc_req_s & ~(VC_ONE << lock_vc_r);
        end else begin
            search_start_s = rr_ptr_r;
            search_mask_s  = vc_req_s;
        end
        {pick_v_s, pick_vc_s} = find_req(search_start_s, search_mask_s);
    end

    // Arbitration lock and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_v_r  <= 1'b0;
            lock_vc_r <= '0;
            rr_ptr_r  <= '0;
        end else if (!lock_v_r) begin
            lock_v_r  <= pick_v_s;
            lock_vc_r <= pick_v_s ? pick_vc_s : lock_vc_r;
        end else if (grant_s) begin
            rr_ptr_r  <= rr_next_s;
            lock_v_r  <= pick_v_s;
            lock_vc_r <= pick_v_s ? pick_vc_s : lock_vc_r;
        end else begin
            lock_v_r  <= lock_v_r;
            lock_vc_r <= lock_vc_r;
        end
    end

    // Credit and free pulses, silenced while in reset
    always_comb begin
        credit_s = '0;
        free_s   = '0;
        if (!rst && bus.is_valid_i) begin
            credit_s = VC_ONE << bus.in_vc_i;
        end else begin
            credit_s = '0;
        end
        if (grant_s) begin
            free_s = VC_ONE << lock_vc_r;
        end else begin
            free_s = '0;
        end
    end

    assign bus.credit_signal_o = credit_s;
    assign bus.free_signal_o   = free_s;
    assign bus.err_o           = ~rst & (|vc_err_s);
    assign bus.r_pkt_to_msg_o  = lock_v_r & ~rst;
    assign bus.out_vc_o        = lock_vc_r;
    assign bus.out_len_o       = vc_cnt_s[lock_vc_r];
    assign bus.out_link_o      = vc_pkt_s[lock_vc_r];

endmodule

// File: tb/tb_vc_flits_buffer.sv
// Bench for vc_flits_buffer with 2 VCs of 4 slots: directed vector table,
// hand-written corner sequences, then random traffic against a packet-level model.
module tb_vc_flits_buffer;
    localparam int FW = 32, NVC = 2, MAXL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vc_flits_buffer_if #(.FLIT_WIDTH(FW), .N_VC(NVC), .MAX_PKT_LEN(MAXL)) bus ();
    vc_flits_buffer #(.FLIT_WIDTH(FW), .N_VC(NVC), .MAX_PKT_LEN(MAXL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic        valid;
        logic        vc;
        logic [31:0] flit;
        logic        grant;
        logic [1:0]  credit;
        logic [1:0]  free;
        logic        err;
        logic        req;
        logic        chk_out;
        logic        out_vc;
        logic [2:0]  len;
        logic [127:0] link;
    } vec_t;

    vec_t tbl [19];

    // Packet-level model: per-VC slot array, fill level, completion flag
    logic [31:0] mbuf [NVC][MAXL];
    int          msize [NVC];
    bit          mcmpl [NVC];
    bit          mlock_v;
    int          mlock_vc;
    int          mrr;

    function automatic vec_t mk(input logic v, input logic vc, input logic [31:0] f, input logic g,
                                input logic [1:0] c, input logic [1:0] fr, input logic e, input logic r,
                                input logic co, input logic ovc, input logic [2:0] len, input logic [127:0] link);
        vec_t t;
        t.valid = v; t.vc = vc; t.flit = f; t.grant = g;
        t.credit = c; t.free = fr; t.err = e; t.req = r;
        t.chk_out = co; t.out_vc = ovc; t.len = len; t.link = link;
        return t;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drv(input logic v, input logic vc, input logic [31:0] f, input logic g);
        bus.is_valid_i     = v;
        bus.in_vc_i        = vc;
        bus.in_link_i      = f;
        bus.g_pkt_to_msg_i = g;
    endtask

    task automatic basic(input string name, input logic [1:0] c, input logic [1:0] fr,
                         input logic e, input logic r);
        chk({name, ".credit"}, 128'(bus.credit_signal_o), 128'(c));
        chk({name, ".free"},   128'(bus.free_signal_o),   128'(fr));
        chk({name, ".err"},    128'(bus.err_o),           128'(e));
        chk({name, ".req"},    128'(bus.r_pkt_to_msg_o),  128'(r));
    endtask

    task automatic outchk(input string name, input logic vc, input int len, input logic [127:0] link);
        chk({name, ".out_vc"},  128'(bus.out_vc_o),  128'(vc));
        chk({name, ".out_len"}, 128'(bus.out_len_o), 128'(len));
        for (int k = 0; k < len; k++)
            chk($sformatf("%s.slot%0d", name, k), 128'(bus.out_link_o[k*32 +: 32]), 128'(link[k*32 +: 32]));
    endtask

    task automatic cyc(input logic v, input logic vc, input logic [31:0] f, input logic g);
        drv(v, vc, f, g);
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic int mfind(input int start, input int excl, input bit [1:0] oc);
        for (int k = 0; k < NVC; k++) begin
            int i = (start + k) % NVC;
            if (i != excl && oc[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit model_err(input int vc, input logic [1:0] ty);
        if (mcmpl[vc]) return 1'b1;
        case (ty)
            2'b00, 2'b11: return msize[vc] > 0;
            2'b01:        return (msize[vc] == 0) || (msize[vc] >= MAXL - 1);
            default:      return msize[vc] == 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NVC; v++) begin
            msize[v] = 0;
            mcmpl[v] = 1'b0;
        end
        mlock_v = 1'b0; mlock_vc = 0; mrr = 0;
    endtask

    task automatic model_step(input logic v, input int vc, input logic [31:0] f, input logic g);
        bit [1:0] oc;
        int idx;
        oc = {mcmpl[1], mcmpl[0]};
        if (!mlock_v) begin
            idx = mfind(mrr, -1, oc);
            if (idx >= 0) begin mlock_v = 1'b1; mlock_vc = idx; end
        end else if (g) begin
            mrr = (mlock_vc + 1) % NVC;
            msize[mlock_vc] = 0;
            mcmpl[mlock_vc] = 1'b0;
            idx = mfind(mrr, mlock_vc, oc);
            if (idx >= 0) mlock_vc = idx;
            else mlock_v = 1'b0;
        end
        if (v && !oc[vc]) begin
            case (f[31:30])
                2'b00: begin mbuf[vc][0] = f; msize[vc] = 1; end
                2'b11: begin mbuf[vc][0] = f; msize[vc] = 1; mcmpl[vc] = 1'b1; end
                2'b01: if (msize[vc] > 0) begin
                    if (msize[vc] < MAXL - 1) begin mbuf[vc][msize[vc]] = f; msize[vc]++; end
                    else msize[vc] = 0;
                end
                default: if (msize[vc] > 0) begin
                    mbuf[vc][msize[vc]] = f; msize[vc]++; mcmpl[vc] = 1'b1;
                end
            endcase
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic        rv, rg, rvc;
    logic [31:0] rf;
    logic [1:0]  rty;
    int          rsel;
    logic [127:0] elink;

    initial begin
        tbl[0]  = mk(1, 0, 32'h0000_00A1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 3'd0, 128'h0);
        tbl[1]  = mk(1, 0, 32'h4000_00A2, 0, 2'b01, 2'b00, 0, 0, 0, 0, 3'd0, 128'h0);
        tbl[2]  = mk(1, 0, 32'h8000_00A3, 0, 2'b01, 2'b00, 0, 0, 0, 0, 3'd0, 128'h0);
        tbl[3]  = mk(0, 0, 32'h0,         0, 2'b00, 2'b00, 0, 0, 0, 0, 3'd0, 128'h0);
        tbl[4]  = mk(0, 0, 32'h0,         0, 2'b00, 2'b00, 0, 1, 1, 0, 3'd3,
                     {32'h0, 32'h8000_00A3, 32'h4000_00A2, 32'h0000_00A1});
        tbl[5]  = mk(0, 0, 32'h0,         1, 2'b00, 2'b01, 0, 1, 1, 0, 3'd3,
                     {32'h0, 32'h8000_00A3, 32'h4000_00A2, 32'h0000_00A1});
        tbl[6]  = mk(0, 0, 32'h0,         0, 2'b00, 2'b00, 0, 0, 0, 0, 3'd0, 128'h0);
        tbl[7]  = mk(1, 1, 32'hC000_0011, 0, 2'b10, 2'b00, 0, 0, 0, 0, 3'd0, 128'h0);
        tbl[8]  = mk(0, 0, 32'h0,         0, 2'b00, 2'b00, 0, 0, 0, 0, 3'd0, 128'h0);
        tbl[9]  = mk(0, 0, 32'h0,         1, 2'b00, 2'b10, 0, 1, 1, 1, 3'd1, {96'h0, 32'hC000_0011});
        tbl[10] = mk(0, 0, 32'h0,         1, 2'b00, 2'b00, 0, 0, 0, 0, 3'd0, 128'h0);
        tbl[11] = mk(1, 1, 32'h4000_0005, 0, 2'b10, 2'b00, 1, 0, 0, 0, 3'd0, 128'h0);
        tbl[12] = mk(0, 0, 32'h0,         0, 2'b00, 2'b00, 0, 0, 0, 0, 3'd0, 128'h0);
        tbl[13] = mk(1, 0, 32'h0000_0013, 0, 2'b01, 2'b00, 0, 0, 0, 0, 3'd0, 128'h0);
        tbl[14] = mk(1, 0, 32'h4000_0014, 0, 2'b01, 2'b00, 0, 0, 0, 0, 3'd0, 128'h0);
        tbl[15] = mk(1, 0, 32'h4000_0015, 0, 2'b01, 2'b00, 0, 0, 0, 0, 3'd0, 128'h0);
        tbl[16] = mk(1, 0, 32'h4000_0016, 0, 2'b01, 2'b00, 1, 0, 0, 0, 3'd0, 128'h0);
        tbl[17] = mk(1, 0, 32'h8000_0017, 0, 2'b01, 2'b00, 1, 0, 0, 0, 3'd0, 128'h0);
        tbl[18] = mk(0, 0, 32'h0,         0, 2'b00, 2'b00, 0, 0, 0, 0, 3'd0, 128'h0);

        // Reset with traffic present: all pulses and the request must stay low
        rst = 1'b1;
        drv(1, 1, 32'hC000_0099, 1);
        nxt();
        @(negedge clk);
        basic("reset", 2'b00, 2'b00, 0, 0);
        nxt();
        rst = 1'b0;
        drv(0, 0, 32'h0, 0);

        for (int i = 0; i < 19; i++) begin
            drv(tbl[i].valid, tbl[i].vc, tbl[i].flit, tbl[i].grant);
            @(negedge clk);
            basic($sformatf("row%0d", i), tbl[i].credit, tbl[i].free, tbl[i].err, tbl[i].req);
            if (tbl[i].chk_out) outchk($sformatf("row%0d", i), tbl[i].out_vc, int'(tbl[i].len), tbl[i].link);
            nxt();
        end

        // Two packets pending: grant of VC0 locks VC1 at the same edge
        cyc(1, 0, 32'hC000_0030, 0); basic("b2b.c1", 2'b01, 2'b00, 0, 0); nxt();
        cyc(1, 1, 32'hC000_0031, 0); basic("b2b.c2", 2'b10, 2'b00, 0, 0); nxt();
        cyc(0, 0, 32'h0, 1); basic("b2b.c3", 2'b00, 2'b01, 0, 1);
        outchk("b2b.c3", 0, 1, {96'h0, 32'hC000_0030}); nxt();
        cyc(0, 0, 32'h0, 1); basic("b2b.c4", 2'b00, 2'b10, 0, 1);
        outchk("b2b.c4", 1, 1, {96'h0, 32'hC000_0031}); nxt();
        cyc(0, 0, 32'h0, 0); basic("b2b.c5", 2'b00, 2'b00, 0, 0); nxt();

        // Interleaved packets on both VCs
        cyc(1, 0, 32'h0000_00B0, 0); basic("il.c1", 2'b01, 2'b00, 0, 0); nxt();
        cyc(1, 1, 32'h0000_00C0, 0); basic("il.c2", 2'b10, 2'b00, 0, 0); nxt();
        cyc(1, 0, 32'h8000_00B1, 0); basic("il.c3", 2'b01, 2'b00, 0, 0); nxt();
        cyc(1, 1, 32'h4000_00C1, 0); basic("il.c4", 2'b10, 2'b00, 0, 0); nxt();
        cyc(1, 1, 32'h8000_00C2, 0); basic("il.c5", 2'b10, 2'b00, 0, 1); nxt();
        cyc(0, 0, 32'h0, 1); basic("il.c6", 2'b00, 2'b01, 0, 1);
        outchk("il.c6", 0, 2, {64'h0, 32'h8000_00B1, 32'h0000_00B0}); nxt();
        cyc(0, 0, 32'h0, 1); basic("il.c7", 2'b00, 2'b10, 0, 1);
        outchk("il.c7", 1, 3, {32'h0, 32'h8000_00C2, 32'h4000_00C1, 32'h0000_00C0}); nxt();
        cyc(0, 0, 32'h0, 0); basic("il.c8", 2'b00, 2'b00, 0, 0); nxt();

        // Reset while VC0 is locked and not granted
        cyc(1, 0, 32'hC000_0060, 0); basic("rl.c1", 2'b01, 2'b00, 0, 0); nxt();
        cyc(0, 0, 32'h0, 0); nxt();
        cyc(0, 0, 32'h0, 0); basic("rl.c3", 2'b00, 2'b00, 0, 1); nxt();
        rst = 1'b1;
        cyc(1, 0, 32'h4000_0000, 1); basic("rl.rst", 2'b00, 2'b00, 0, 0); nxt();
        rst = 1'b0;
        cyc(0, 0, 32'h0, 1); basic("rl.after", 2'b00, 2'b00, 0, 0); nxt();
        cyc(1, 0, 32'hC000_0062, 0); basic("rl.ht", 2'b01, 2'b00, 0, 0); nxt();
        cyc(0, 0, 32'h0, 0); basic("rl.wait", 2'b00, 2'b00, 0, 0); nxt();
        cyc(0, 0, 32'h0, 1); basic("rl.req", 2'b00, 2'b01, 0, 1);
        outchk("rl.req", 0, 1, {96'h0, 32'hC000_0062}); nxt();

        // Random traffic against the packet model
        rst = 1'b1;
        drv(0, 0, 32'h0, 0);
        nxt(); nxt();
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 800; n++) begin
            rv   = ($urandom_range(0, 3) != 0);
            rvc  = 1'($urandom_range(0, 1));
            rsel = $urandom_range(0, 99);
            rty  = (rsel < 20) ? 2'b00 : (rsel < 55) ? 2'b01 : (rsel < 85) ? 2'b10 : 2'b11;
            rf   = {rty, 30'($urandom)};
            rg   = 1'($urandom_range(0, 1));
            drv(rv, rvc, rf, rg);
            @(negedge clk);
            basic($sformatf("rnd%0d", n),
                  rv ? (2'b01 << rvc) : 2'b00,
                  (mlock_v && rg) ? (2'b01 << mlock_vc) : 2'b00,
                  rv && model_err(int'(rvc), rty),
                  mlock_v);
            if (mlock_v) begin
                elink = '0;
                for (int k = 0; k < msize[mlock_vc]; k++) elink[k*32 +: 32] = mbuf[mlock_vc][k];
                outchk($sformatf("rnd%0d", n), 1'(mlock_vc), msize[mlock_vc], elink);
            end
            model_step(rv, int'(rvc), rf, rg);
            nxt();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
